// File: rtl/semaforo_multi.sv
// Multi-channel traffic-light lamp driver: registered decode of per-channel codes,
// minimum-yellow interlock on GREEN->RED, and a shared yellow flash for the OFF code.
//
// state  | meaning
// RED    | red lamp on
// YELLOW | yellow lamp on (requested, or inserted while forced)
// GREEN  | green lamp on
// OFF    | dark, or flashing yellow when blink_en is set
module semaforo_multi #(
    parameter int CHANNELS   = 2,
    parameter int MIN_YELLOW = 3,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2*CHANNELS-1:0] light,
    input  logic                  blink_en,
    output logic [CHANNELS-1:0]   red,
    output logic [CHANNELS-1:0]   yellow,
    output logic [CHANNELS-1:0]   green,
    output logic [CHANNELS-1:0]   forced
);

    localparam int TW = $clog2(MIN_YELLOW + 1);
    localparam int CW = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b10,
        OFF    = 2'b11
    } disp_t;

    disp_t               disp_q  [CHANNELS];
    disp_t               disp_d  [CHANNELS];
    logic [TW-1:0]       timer_q [CHANNELS];
    logic [TW-1:0]       timer_d [CHANNELS];
    logic [CHANNELS-1:0] forced_q;
    logic [CHANNELS-1:0] forced_d;
    logic [CW-1:0]       cnt_q;
    logic                phase_q;
    logic                blink_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                disp_q[i]  <= RED;
                timer_q[i] <= '0;
            end
            forced_q <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            blink_q  <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                disp_q[i]  <= disp_d[i];
                timer_q[i] <= timer_d[i];
            end
            forced_q <= forced_d;
            blink_q  <= blink_en;
            if (cnt_q == CW'(BLINK_DIV - 1)) begin
                cnt_q   <= '0;
                phase_q <= ~phase_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        forced_d = forced_q;
        for (int i = 0; i < CHANNELS; i++) begin
            disp_d[i]  = disp_q[i];
            timer_d[i] = timer_q[i];
            if (forced_q[i]) begin
                // Request is ignored until the inserted yellow has run its course.
                if (timer_q[i] != '0) begin
                    timer_d[i] = timer_q[i] - 1'b1;
                end else begin
                    forced_d[i] = 1'b0;
                    disp_d[i]   = disp_t'(light[2*i +: 2]);
                end
            end else if (disp_q[i] == GREEN && disp_t'(light[2*i +: 2]) == RED) begin
                disp_d[i]   = YELLOW;
                forced_d[i] = 1'b1;
                timer_d[i]  = TW'(MIN_YELLOW - 1);
            end else begin
                disp_d[i] = disp_t'(light[2*i +: 2]);
            end
        end
    end

    always_comb begin
        red    = '0;
        yellow = '0;
        green  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            red[i]    = (disp_q[i] == RED);
            green[i]  = (disp_q[i] == GREEN);
            yellow[i] = (disp_q[i] == YELLOW) || (disp_q[i] == OFF && blink_q && phase_q);
        end
    end

    assign forced = forced_q;

endmodule

// File: tb/tb_semaforo_multi.sv
// Bench for semaforo_multi: directed scenarios plus random codes, every cycle
// compared against a cycle-count model of lamps, interlock and flash phase.
module tb_semaforo_multi;

    localparam int CH = 2;
    localparam int MY = 3;
    localparam int BD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2*CH-1:0] light = '0;
    logic          blink_en = 1'b0;
    logic [CH-1:0] red, yellow, green, forced;

    int n_checks = 0;
    int n_fail   = 0;

    int m_code [CH];
    int m_hold [CH];
    int m_edges;
    bit m_blink;

    semaforo_multi #(.CHANNELS(CH), .MIN_YELLOW(MY), .BLINK_DIV(BD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .light    (light),
        .blink_en (blink_en),
        .red      (red),
        .yellow   (yellow),
        .green    (green),
        .forced   (forced)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Model: a code per channel, a count of yellow cycles still owed, and edges since reset.
    task automatic model_edge();
        int code;
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                m_code[c] = 0;
                m_hold[c] = 0;
            end
            m_edges = 0;
        end else begin
            m_edges++;
            for (int c = 0; c < CH; c++) begin
                code = int'(light[2*c +: 2]);
                if (m_hold[c] > 0) begin
                    m_hold[c]--;
                    if (m_hold[c] == 0) m_code[c] = code;
                end else if (m_code[c] == 2 && code == 0) begin
                    m_code[c] = 1;
                    m_hold[c] = MY;
                end else begin
                    m_code[c] = code;
                end
            end
        end
        m_blink = rst_n ? blink_en : 1'b0;
    endtask

    task automatic step();
        logic [CH-1:0] er, ey, eg, ef;
        bit phase;
        @(posedge clk);
        model_edge();
        #1;
        phase = ((m_edges / BD) % 2) == 1;
        for (int c = 0; c < CH; c++) begin
            er[c] = (m_code[c] == 0);
            eg[c] = (m_code[c] == 2);
            ey[c] = (m_code[c] == 1) || (m_code[c] == 3 && m_blink && phase);
            ef[c] = (m_hold[c] > 0);
        end
        chk("red", 8'(red), 8'(er));
        chk("yellow", 8'(yellow), 8'(ey));
        chk("green", 8'(green), 8'(eg));
        chk("forced", 8'(forced), 8'(ef));
        chk("one_lamp", 8'((red & yellow) | (red & green) | (yellow & green)), 8'd0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // Reset with both GREEN requested, then release
        rst_n = 1'b0; light = 4'b1010; blink_en = 1'b0;
        run(2);
        chk("rst_red", 8'(red), 8'h03);
        rst_n = 1'b1;
        run(1);
        chk("rel_green", 8'(green), 8'h03);

        // Interlock on ch0, ch1 held GREEN
        run(2);
        light = 4'b1000;
        run(3);
        chk("il_yel_k2", 8'(yellow), 8'h01);
        run(1);
        chk("il_red_k3", 8'(red), 8'h01);
        run(2);

        // Request changes back to GREEN mid-interlock
        light = 4'b1010;
        run(2);
        light = 4'b1000;
        run(1);
        light = 4'b1010;
        run(2);
        chk("mid_forced", 8'(forced), 8'h01);
        run(1);
        chk("mid_green", 8'(green), 8'h03);
        run(1);

        // Flashing from reset
        rst_n = 1'b0; light = 4'b1111; blink_en = 1'b1;
        run(1);
        rst_n = 1'b1;
        run(12);
        blink_en = 1'b0;
        run(2);
        blink_en = 1'b1;
        run(5);

        // Reset in the middle of an interlock
        light = 4'b1010; blink_en = 1'b0;
        run(2);
        light = 4'b1000;
        run(1);
        rst_n = 1'b0;
        run(1);
        chk("rst_il_forced", 8'(forced), 8'h00);
        rst_n = 1'b1; light = 4'b0000;
        run(3);
        chk("rst_il_red", 8'(red), 8'h03);

        // Direct transitions
        light = 4'b0000; run(1);
        light = 4'b1010; run(1);
        chk("r2g_forced", 8'(forced), 8'h00);
        light = 4'b0101; run(1);
        light = 4'b0000; run(1);
        chk("y2r_red", 8'(red), 8'h03);
        light = 4'b1010; run(1);
        light = 4'b1111; run(1);
        chk("g2off_dark", 8'(red | yellow | green), 8'h00);

        // Random codes with occasional blink toggles and resets
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(3) == 0) light[2*c +: 2] = 2'($urandom_range(3));
            if ($urandom_range(15) == 0) blink_en = ~blink_en;
            rst_n = ($urandom_range(199) != 0);
            step();
        end
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
